// File: rtl/mo_mul_lanes.sv
// LANES-wide pipelined Montgomery multiplier (a*b*R^-1 mod Q, lazy result in [0,2Q)) behind one
// bubble-collapsing valid/ready pipeline. Define MO_MUL_FULL_REDUCE_EN for a final canonicalising stage.
module mo_mul_lanes #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned Q          = 3329,
  parameter int unsigned LANES      = 2,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_mode,
  input  logic [TAG_WIDTH-1:0]            in_tag,
  input  logic [LANES*DATA_WIDTH-1:0]     a,
  input  logic [LANES*DATA_WIDTH-1:0]     b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*DATA_WIDTH-1:0]     result,
  output logic [TAG_WIDTH-1:0]            out_tag
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned LW = LANES * DATA_WIDTH;
`ifdef MO_MUL_FULL_REDUCE_EN
  localparam int unsigned L  = STAGES + 1;
`else
  localparam int unsigned L  = STAGES;
`endif
  // First stage holding the reduced value t; with only two stages the whole REDC sits in stage 2.
  localparam int unsigned T0 = (STAGES == 2) ? 2 : 3;

  function automatic logic [63:0] calc_qinv();
    logic [63:0] inv;
    logic [63:0] mask;
    mask = (64'd1 << DATA_WIDTH) - 64'd1;
    inv  = 64'(Q);
    for (int i = 0; i < 6; i++) inv = inv * (64'd2 - 64'(Q) * inv);
    return ((~inv) + 64'd1) & mask;
  endfunction

  function automatic logic [63:0] calc_r2();
    logic [63:0] rm;
    rm = (64'd1 << DATA_WIDTH) % 64'(Q);
    return (rm * rm) % 64'(Q);
  endfunction

  localparam int unsigned   QINV   = 32'(calc_qinv());
  localparam int unsigned   R2     = 32'(calc_r2());
  localparam logic [DW-1:0] Q_W    = DW'(Q);
  localparam logic [DW-1:0] QINV_W = DW'(QINV);
  localparam logic [DW-1:0] R2_W   = DW'(R2);

  if ((Q % 2 == 0) || (64'(4) * 64'(Q) >= (64'd1 << DATA_WIDTH))) begin : g_bad_q
    $error("mo_mul_lanes: Q must be odd and satisfy 4*Q < 2**DATA_WIDTH");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("mo_mul_lanes: STAGES must be at least 2");
  end

  function automatic logic [PW-1:0] lane_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return PW'(x) * PW'(y);
  endfunction

  function automatic logic [DW-1:0] lane_mfac(input logic [DW-1:0] p_lo);
    return p_lo * QINV_W;
  endfunction

  // p + m*Q is an exact multiple of R and stays below R^2 for in-contract operands.
  function automatic logic [DW-1:0] lane_redc(input logic [PW-1:0] p, input logic [DW-1:0] m);
    logic [PW-1:0] s;
    s = p + PW'(m) * PW'(Q_W);
    return DW'(s >> DW);
  endfunction

  function automatic logic [DW-1:0] lane_mont(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [PW-1:0] p;
    p = lane_mul(x, y);
    return lane_redc(p, lane_mfac(p[DW-1:0]));
  endfunction

  logic [L:1]           v_q, v_d, en_c;
  logic [TAG_WIDTH-1:0] tag_q [1:L];
  logic [TAG_WIDTH-1:0] tag_d [1:L];
  logic [LW-1:0]        opa_q, opa_d, opb_q, opb_d;
  logic [LW-1:0]        tcore_c;
  logic [LW-1:0]        t_q [T0:STAGES];
  logic [LW-1:0]        t_d [T0:STAGES];

  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin : p_enable
    logic acc;
    acc  = out_ready;
    en_c = '0;
    for (int k = L; k >= 1; k--) begin
      acc     = acc | ~v_q[k];
      en_c[k] = acc;
    end
  end

  always_comb begin : p_next
    v_d   = v_q;
    tag_d = tag_q;
    opa_d = opa_q;
    opb_d = opb_q;
    t_d   = t_q;
    if (en_c[1]) begin
      v_d[1]   = in_valid;
      tag_d[1] = in_tag;
      opa_d    = a;
      opb_d    = in_mode ? {LANES{R2_W}} : b;
    end
    for (int k = 2; k <= L; k++) begin
      if (en_c[k]) begin
        v_d[k]   = v_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
    if (en_c[T0]) t_d[T0] = tcore_c;
    for (int k = T0 + 1; k <= STAGES; k++) begin
      if (en_c[k]) t_d[k] = t_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      v_q   <= '0;
      opa_q <= '0;
      opb_q <= '0;
      for (int k = 1; k <= L; k++) tag_q[k] <= '0;
      for (int k = T0; k <= STAGES; k++) t_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      tag_q <= tag_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      t_q   <= t_d;
    end
  end

  if (STAGES == 2) begin : g_core_short
    always_comb begin : p_core
      tcore_c = '0;
      for (int i = 0; i < LANES; i++)
        tcore_c[i*DW +: DW] = lane_mont(opa_q[i*DW +: DW], opb_q[i*DW +: DW]);
    end
  end else begin : g_core_split
    // Stage 2 holds the product and m; stage 3 finishes the reduction.
    logic [LANES*PW-1:0] p_q, p_d;
    logic [LW-1:0]       m_q, m_d;

    always_comb begin : p_core
      p_d     = p_q;
      m_d     = m_q;
      tcore_c = '0;
      for (int i = 0; i < LANES; i++) begin
        if (en_c[2]) begin
          p_d[i*PW +: PW] = lane_mul(opa_q[i*DW +: DW], opb_q[i*DW +: DW]);
          m_d[i*DW +: DW] = lane_mfac(p_d[i*PW +: DW]);
        end
        tcore_c[i*DW +: DW] = lane_redc(p_q[i*PW +: PW], m_q[i*DW +: DW]);
      end
    end

    always_ff @(posedge clk or posedge rst) begin : p_core_regs
      if (rst) begin
        p_q <= '0;
        m_q <= '0;
      end else begin
        p_q <= p_d;
        m_q <= m_d;
      end
    end
  end

`ifdef MO_MUL_FULL_REDUCE_EN
  logic [LW-1:0] red_q, red_d;

  // Lazy t is below 2Q, so a single conditional subtract makes it canonical.
  always_comb begin : p_reduce
    red_d = red_q;
    if (en_c[L]) begin
      for (int i = 0; i < LANES; i++)
        red_d[i*DW +: DW] = (t_q[STAGES][i*DW +: DW] >= Q_W) ?
                            t_q[STAGES][i*DW +: DW] - Q_W : t_q[STAGES][i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_reduce_regs
    if (rst) red_q <= '0;
    else     red_q <= red_d;
  end

  assign result = red_q;
`else
  assign result = t_q[STAGES];
`endif

  assign out_valid = v_q[L];
  assign out_tag   = tag_q[L];
  assign in_ready  = en_c[1];

endmodule

// File: tb/tb_mo_mul_lanes.sv
// Self-checking bench for mo_mul_lanes: arithmetic Montgomery reference model plus an in-order scoreboard.
// Follows MO_MUL_FULL_REDUCE_EN (canonical results, one extra cycle of latency).
module tb_mo_mul_lanes;

  localparam int unsigned DW     = 14;
  localparam int unsigned Q      = 3329;
  localparam int unsigned LANES  = 2;
  localparam int unsigned STAGES = 3;
  localparam int unsigned TW     = 4;
  localparam int unsigned LW     = LANES * DW;
  localparam int unsigned R      = 1 << DW;
`ifdef MO_MUL_FULL_REDUCE_EN
  localparam int unsigned L      = STAGES + 1;
  localparam bit          FULL   = 1'b1;
`else
  localparam int unsigned L      = STAGES;
  localparam bit          FULL   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [TW-1:0] in_tag, out_tag;
  logic [LW-1:0] a, b, result;

  typedef struct packed {
    logic [LW-1:0] res;
    logic [TW-1:0] tag;
    logic [LW-1:0] av;
    logic [LW-1:0] bv;
    logic          md;
  } exp_t;

  exp_t        exp_q[$];
  int          checks, errors;
  int unsigned r2, qinv;

  mo_mul_lanes #(.DATA_WIDTH(DW), .Q(Q), .LANES(LANES), .STAGES(STAGES), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_tag(in_tag), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: Montgomery REDC written straight from its arithmetic definition.
  function automatic logic [DW-1:0] ref_lane(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic md);
    longint unsigned p, m, t;
    p = 64'(x) * (md ? 64'(r2) : 64'(y));
    m = ((p % 64'(R)) * 64'(qinv)) % 64'(R);
    t = (p + m * 64'(Q)) / 64'(R);
    if (FULL && t >= 64'(Q)) t = t - 64'(Q);
    return DW'(t);
  endfunction

  function automatic logic [LW-1:0] ref_vec(input logic [LW-1:0] av, input logic [LW-1:0] bv, input logic md);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = ref_lane(av[i*DW +: DW], bv[i*DW +: DW], md);
    return r;
  endfunction

  // Residue class of R*x, which must equal that of the plain product a*b'.
  function automatic int unsigned mont_cls(input logic [DW-1:0] x);
    return 32'((64'(R) * 64'(x)) % 64'(Q));
  endfunction

  function automatic int unsigned golden(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic md);
    return 32'((64'(x) * (md ? 64'(r2) : 64'(y))) % 64'(Q));
  endfunction

  function automatic logic [LW-1:0] rand_ops();
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'($urandom_range(2*Q-1, 0));
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [LW-1:0] av, input logic [LW-1:0] bv, input logic md,
                                  input logic [TW-1:0] tg);
    exp_t e;
    e.res = ref_vec(av, bv, md);
    e.tag = tg;
    e.av  = av;
    e.bv  = bv;
    e.md  = md;
    return e;
  endfunction

  // Drives one transaction with out_ready high; lat = cycles from acceptance to out_valid, -1 on timeout.
  task automatic do_txn(input logic [LW-1:0] av, input logic [LW-1:0] bv, input logic md,
                        input logic [TW-1:0] tg, output logic [LW-1:0] res, output logic [TW-1:0] otag,
                        output int lat);
    int k;
    @(negedge clk);
    a = av; b = bv; in_mode = md; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    res  = result;
    otag = out_tag;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL rst_result got %h exp 0", result); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL rst_out_tag got %h exp 0", out_tag); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL rel_result got %h exp 0", result); end
  endtask

  task automatic test_to_mont();
    logic [LW-1:0] av, bv, res;
    logic [TW-1:0] tg;
    int            lat;
    av = {LANES{DW'(1)}};
    bv = rand_ops();
    do_txn(av, bv, 1'b1, TW'(5), res, tg, lat);
    checks++; if (lat != int'(L)) begin errors++; $display("FAIL to_mont_latency got %0d exp %0d", lat, L); end
    checks++; if (tg !== TW'(5)) begin errors++; $display("FAIL to_mont_tag got %0d exp 5", tg); end
    checks++; if (res !== ref_vec(av, bv, 1'b1)) begin
      errors++; $display("FAIL to_mont_result got %h exp %h", res, ref_vec(av, bv, 1'b1));
    end
    for (int i = 0; i < LANES; i++) begin
      checks++;
      if (32'(res[i*DW +: DW]) % Q != 3068) begin
        errors++; $display("FAIL to_mont_cong lane %0d got %0d exp 3068 mod Q", i, res[i*DW +: DW]);
      end
    end
  endtask

  task automatic test_mont();
    logic [LW-1:0] av, bv, res;
    logic [TW-1:0] tg;
    int            lat;
    av = {LANES{DW'(3068)}};
    bv = {LANES{DW'(1)}};
    do_txn(av, bv, 1'b0, TW'(9), res, tg, lat);
    checks++; if (lat != int'(L)) begin errors++; $display("FAIL mont_latency got %0d exp %0d", lat, L); end
    checks++; if (res !== ref_vec(av, bv, 1'b0)) begin
      errors++; $display("FAIL mont_one got %h exp %h", res, ref_vec(av, bv, 1'b0));
    end
    for (int i = 0; i < LANES; i++) begin
      checks++;
      if ((32'(res[i*DW +: DW]) % Q != 1) || (32'(res[i*DW +: DW]) >= 2*Q)) begin
        errors++; $display("FAIL mont_one_cong lane %0d got %0d exp 1 mod Q below 2Q", i, res[i*DW +: DW]);
      end
    end
    av = '0;
    bv = rand_ops();
    do_txn(av, bv, 1'b0, TW'(10), res, tg, lat);
    checks++; if (res !== '0) begin errors++; $display("FAIL mont_zero got %h exp 0", res); end
    checks++; if (tg !== TW'(10)) begin errors++; $display("FAIL mont_zero_tag got %0d exp 10", tg); end
  endtask

  task automatic test_boundary();
    logic [LW-1:0] av, res;
    logic [TW-1:0] tg;
    int            lat;
    av = {LANES{DW'(2*Q-1)}};
    for (int md = 0; md < 2; md++) begin
      do_txn(av, av, md[0], TW'(md + 2), res, tg, lat);
      checks++; if (res !== ref_vec(av, av, md[0])) begin
        errors++; $display("FAIL bound_result mode %0d got %h exp %h", md, res, ref_vec(av, av, md[0]));
      end
      for (int i = 0; i < LANES; i++) begin
        checks++;
        if (32'(res[i*DW +: DW]) >= (FULL ? Q : 2*Q)) begin
          errors++; $display("FAIL bound_range mode %0d lane %0d got %0d", md, i, res[i*DW +: DW]);
        end
        checks++;
        if (mont_cls(res[i*DW +: DW]) != golden(DW'(2*Q-1), DW'(2*Q-1), md[0])) begin
          errors++; $display("FAIL bound_cong mode %0d lane %0d got %0d exp %0d", md, i,
                             mont_cls(res[i*DW +: DW]), golden(DW'(2*Q-1), DW'(2*Q-1), md[0]));
        end
      end
    end
  endtask

  // With the output blocked, scattered offers must still fill every stage.
  task automatic test_bubble_collapse();
    logic [LW-1:0] av, bv;
    logic          md;
    exp_t          e;
    int            sent, c;
    exp_q.delete();
    sent = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if ($urandom_range(1, 0) == 1) begin
        av = rand_ops(); bv = rand_ops(); md = 1'($urandom_range(1, 0));
        a = av; b = bv; in_mode = md; in_tag = TW'(sent); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(mk_exp(a, b, in_mode, in_tag));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (sent != int'(L)) begin errors++; $display("FAIL bubble_fill got %0d exp %0d", sent, L); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_full_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bubble_out_valid got %b exp 1", out_valid); end
    out_ready = 1'b1;
    c = 0;
    while (exp_q.size() > 0 && c < 20) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (result !== e.res || out_tag !== e.tag) begin
          errors++; $display("FAIL bubble_drain got %h/%0d exp %h/%0d", result, out_tag, e.res, e.tag);
        end
      end
      @(negedge clk);
      c++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bubble_lost got %0d left exp 0", exp_q.size()); end
  endtask

  // Lane 0 walks a over [0,2Q); back-to-back with out_ready high must give one result per cycle.
  task automatic test_sweep();
    localparam int N = 2 * Q;
    logic [LW-1:0] av, bv;
    exp_t          e;
    int            sent, got, cyc;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    while (got < N && cyc < N + 50) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'b1;
      if (sent < N) begin
        av = rand_ops(); bv = rand_ops();
        av[DW-1:0] = DW'(sent);
        a = av; b = bv; in_mode = 1'b0; in_tag = TW'(sent); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (sent < N) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready got %b exp 1", in_ready); end
      end
      if (got > 0 && got < N) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_gap got %b exp 1 after %0d", out_valid, got); end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL sweep_extra got tag %0d exp none", out_tag);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (result !== e.res || out_tag !== e.tag) begin
            errors++; $display("FAIL sweep_result got %h/%0d exp %h/%0d", result, out_tag, e.res, e.tag);
          end
          checks++;
          if (mont_cls(result[DW-1:0]) != golden(e.av[DW-1:0], e.bv[DW-1:0], 1'b0)) begin
            errors++; $display("FAIL sweep_cong got %0d exp %0d", mont_cls(result[DW-1:0]),
                               golden(e.av[DW-1:0], e.bv[DW-1:0], 1'b0));
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(mk_exp(a, b, in_mode, in_tag));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (got != N) begin errors++; $display("FAIL sweep_count got %0d exp %0d", got, N); end
  endtask

  task automatic test_random_stall();
    localparam int N = 10000;
    logic [LW-1:0] hold_res;
    logic [TW-1:0] hold_tag;
    logic          pend, prev_stall;
    exp_t          e;
    int            sent, got, cyc;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; pend = 1'b0; prev_stall = 1'b0;
    hold_res = '0; hold_tag = '0;
    while (got < N && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!pend && sent < N && $urandom_range(99, 0) < 70) begin
        a = rand_ops(); b = rand_ops(); in_mode = 1'($urandom_range(1, 0)); in_tag = TW'(sent);
        pend = 1'b1;
      end
      in_valid  = pend;
      out_ready = 1'($urandom_range(1, 0));
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || result !== hold_res || out_tag !== hold_tag) begin
          errors++; $display("FAIL stall_hold got %b/%h/%0d exp 1/%h/%0d", out_valid, result, out_tag,
                             hold_res, hold_tag);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL stall_extra got tag %0d exp none", out_tag);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (result !== e.res || out_tag !== e.tag) begin
            errors++; $display("FAIL stall_result got %h/%0d exp %h/%0d", result, out_tag, e.res, e.tag);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(mk_exp(a, b, in_mode, in_tag));
        sent++;
        pend = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      hold_res   = result;
      hold_tag   = out_tag;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (got != N) begin errors++; $display("FAIL stall_count got %0d exp %0d", got, N); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_left got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    int sent;
    sent = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      a = rand_ops(); b = rand_ops(); in_mode = 1'b0; in_tag = TW'(k + 1); in_valid = 1'b1;
      #1;
      if (in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (sent != 3) begin errors++; $display("FAIL mid_accept got %0d exp 3", sent); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    checks++; if (result !== '0 || out_tag !== '0) begin
      errors++; $display("FAIL mid_rst_data got %h/%0d exp 0/0", result, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost cycle %0d got %b exp 0", k, out_valid); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_tag = '0; a = '0; b = '0; out_ready = 1'b0;
    r2 = 32'((64'(R) * 64'(R)) % 64'(Q));
    qinv = 0;
    for (int x = 0; x < int'(R); x++) begin
      if ((64'(Q) * 64'(x)) % 64'(R) == 64'(R - 1)) qinv = 32'(x);
    end
    test_reset();
    test_to_mont();
    test_mont();
    test_boundary();
    test_bubble_collapse();
    test_sweep();
    test_random_stall();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
